// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator operand-stack controller.
// Holds the sequencer state encoding (which doubles as the status code),
// the ALU opcode encoding and the status field width.
package rpn_pkg;

    localparam int unsigned STATUS_W = 3;

    // Sequencer states; the encoding is exported directly on the status port
    typedef enum logic [STATUS_W-1:0] {
        ST_IDLE      = 3'b000,
        ST_PUSH      = 3'b001,
        ST_POP       = 3'b010,
        ST_FETCH     = 3'b011,
        ST_EXEC      = 3'b100,
        ST_WRITEBACK = 3'b101
    } state_t;

    // Operations understood by the shared ALU
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/rpn_stack_regfile.sv
// Operand stack storage: DEPTH x WIDTH array with one write port, an entry
// counter with increment/decrement, and combinational reads of the top two
// entries.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   we, waddr, wdata   single write port
//   inc, dec           count +1 / -1 (never asserted together)
//   top                stack[count-1], 0 when empty
//   below              stack[count-2], 0 when fewer than two entries
//   count              number of entries held
module rpn_stack_regfile #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] below,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [CNT_W-1:0] cnt_m1;
    logic [CNT_W-1:0] cnt_m2;

    assign cnt_m1 = count - CNT_W'(1);
    assign cnt_m2 = count - CNT_W'(2);

    // Storage and entry counter
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack[i] <= '0;
            end
            count <= '0;
        end else begin
            if (we) begin
                stack[waddr] <= wdata;
            end
            if (inc) begin
                count <= count + CNT_W'(1);
            end else if (dec) begin
                count <= cnt_m1;
            end
        end
    end

    // Top-two reads; empty slots read as zero
    always_comb begin
        top   = '0;
        below = '0;
        if (count != '0) begin
            top = stack[IDX_W'(cnt_m1)];
        end
        if (count >= CNT_W'(2)) begin
            below = stack[IDX_W'(cnt_m2)];
        end
    end

endmodule

// File: rtl/rpn_stack_sequencer.sv
// Operand-stack controller for the RPN calculator. Accepts push (enter),
// drop (undo) and operator commands from the button-pulse logic, and for an
// operator walks the shared combinational ALU through fetch / execute /
// write-back. Top of stack feeds the display path.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   enter_pulse/op_pulse/undo_pulse  one-cycle command pulses (priority in that order)
//   data_in, opcode_in               operand to push, ALU operation
//   alu_result                       combinational ALU output
//   alu_a, alu_b, alu_opcode         registered ALU operands / opcode
//   top, count                       top of stack (0 when empty), entries held
//   busy, status                     not-idle flag, state code
//   err_overflow, err_underflow      sticky error flags, cleared on next accepted command
module rpn_stack_sequencer
    import rpn_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned OPCODE_W = 2,
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1),
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enter_pulse,
    input  logic                op_pulse,
    input  logic                undo_pulse,
    input  logic [WIDTH-1:0]    data_in,
    input  logic [OPCODE_W-1:0] opcode_in,
    input  logic [WIDTH-1:0]    alu_result,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [OPCODE_W-1:0] alu_opcode,
    output logic [WIDTH-1:0]    top,
    output logic [CNT_W-1:0]    count,
    output logic                busy,
    output logic [STATUS_W-1:0] status,
    output logic                err_overflow,
    output logic                err_underflow
);

    state_t              state;
    logic [WIDTH-1:0]    pend_data;
    logic [OPCODE_W-1:0] pend_op;
    logic [WIDTH-1:0]    result_reg;
    logic [WIDTH-1:0]    below;

    logic                rf_we_c;
    logic [IDX_W-1:0]    rf_waddr_c;
    logic [WIDTH-1:0]    rf_wdata_c;
    logic                rf_inc_c;
    logic                rf_dec_c;

    assign busy   = (state != ST_IDLE);
    assign status = state;

    // Sequencer: command acceptance, ALU operand staging, error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            pend_data     <= '0;
            pend_op       <= '0;
            result_reg    <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_opcode    <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Accepting a command clears both flags before its own error is applied
                    if (enter_pulse) begin
                        err_underflow <= 1'b0;
                        if (count < CNT_W'(DEPTH)) begin
                            pend_data    <= data_in;
                            err_overflow <= 1'b0;
                            state        <= ST_PUSH;
                        end else begin
                            err_overflow <= 1'b1;
                        end
                    end else if (op_pulse) begin
                        err_overflow <= 1'b0;
                        if (count >= CNT_W'(2)) begin
                            pend_op       <= opcode_in;
                            err_underflow <= 1'b0;
                            state         <= ST_FETCH;
                        end else begin
                            err_underflow <= 1'b1;
                        end
                    end else if (undo_pulse) begin
                        err_overflow <= 1'b0;
                        if (count != '0) begin
                            err_underflow <= 1'b0;
                            state         <= ST_POP;
                        end else begin
                            err_underflow <= 1'b1;
                        end
                    end
                end
                ST_PUSH: state <= ST_IDLE;
                ST_POP:  state <= ST_IDLE;
                ST_FETCH: begin
                    alu_a      <= below;
                    alu_b      <= top;
                    alu_opcode <= pend_op;
                    state      <= ST_EXEC;
                end
                ST_EXEC: begin
                    // ALU inputs have been stable for a full cycle here
                    result_reg <= alu_result;
                    state      <= ST_WRITEBACK;
                end
                ST_WRITEBACK: state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    // Stack write / count control decoded from the current state
    always_comb begin
        rf_we_c    = 1'b0;
        rf_waddr_c = '0;
        rf_wdata_c = '0;
        rf_inc_c   = 1'b0;
        rf_dec_c   = 1'b0;
        case (state)
            ST_PUSH: begin
                rf_we_c    = 1'b1;
                rf_waddr_c = IDX_W'(count);
                rf_wdata_c = pend_data;
                rf_inc_c   = 1'b1;
            end
            ST_POP: begin
                rf_dec_c = 1'b1;
            end
            ST_WRITEBACK: begin
                rf_we_c    = 1'b1;
                rf_waddr_c = IDX_W'(count - CNT_W'(2));
                rf_wdata_c = result_reg;
                rf_dec_c   = 1'b1;
            end
            default: ;
        endcase
    end

    rpn_stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we_c),
        .waddr (rf_waddr_c),
        .wdata (rf_wdata_c),
        .inc   (rf_inc_c),
        .dec   (rf_dec_c),
        .top   (top),
        .below (below),
        .count (count)
    );

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Directed bench for rpn_stack_sequencer with a simple behavioural ALU.
module tb_rpn_stack_sequencer;
    import rpn_pkg::*;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned OPCODE_W = 2;
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enter_pulse = 1'b0;
    logic                op_pulse = 1'b0;
    logic                undo_pulse = 1'b0;
    logic [WIDTH-1:0]    data_in = '0;
    logic [OPCODE_W-1:0] opcode_in = '0;
    logic [WIDTH-1:0]    alu_result;
    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic [OPCODE_W-1:0] alu_opcode;
    logic [WIDTH-1:0]    top;
    logic [CNT_W-1:0]    count;
    logic                busy;
    logic [STATUS_W-1:0] status;
    logic                err_overflow;
    logic                err_underflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-in for the calculator ALU
    always_comb begin
        case (alu_op_t'(alu_opcode))
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    rpn_stack_sequencer #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .OPCODE_W (OPCODE_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enter_pulse   (enter_pulse),
        .op_pulse      (op_pulse),
        .undo_pulse    (undo_pulse),
        .data_in       (data_in),
        .opcode_in     (opcode_in),
        .alu_result    (alu_result),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_opcode    (alu_opcode),
        .top           (top),
        .count         (count),
        .busy          (busy),
        .status        (status),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_enter(input logic [WIDTH-1:0] d);
        enter_pulse = 1'b1;
        data_in     = d;
        tick();
        enter_pulse = 1'b0;
    endtask

    task automatic pulse_op(input logic [OPCODE_W-1:0] op);
        op_pulse  = 1'b1;
        opcode_in = op;
        tick();
        op_pulse  = 1'b0;
    endtask

    task automatic pulse_undo();
        undo_pulse = 1'b1;
        tick();
        undo_pulse = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_top", 32'(top), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_err_ov", 32'(err_overflow), 0);
        chk("rst_err_un", 32'(err_underflow), 0);
        chk("rst_alu_a", 32'(alu_a), 0);

        // 1: enter 5, enter 3
        pulse_enter(16'd5);
        chk("push1_busy_c1", 32'(busy), 1);
        chk("push1_status_c1", 32'(status), 1);
        chk("push1_count_c1", 32'(count), 0);
        tick();
        chk("push1_busy_c2", 32'(busy), 0);
        chk("push1_top_c2", 32'(top), 5);
        chk("push1_count_c2", 32'(count), 1);
        pulse_enter(16'd3);
        chk("push2_busy_c1", 32'(busy), 1);
        tick();
        chk("push2_top_c2", 32'(top), 3);
        chk("push2_count_c2", 32'(count), 2);

        // 2: {5,3} SUB -> 2
        pulse_op(2'b01);
        chk("sub_status_fetch", 32'(status), 3);
        chk("sub_busy_c1", 32'(busy), 1);
        tick();
        chk("sub_status_exec", 32'(status), 4);
        chk("sub_alu_a", 32'(alu_a), 5);
        chk("sub_alu_b", 32'(alu_b), 3);
        chk("sub_alu_op", 32'(alu_opcode), 1);
        tick();
        chk("sub_status_wb", 32'(status), 5);
        chk("sub_top_c3", 32'(top), 3);
        tick();
        chk("sub_busy_c4", 32'(busy), 0);
        chk("sub_top_c4", 32'(top), 2);
        chk("sub_count_c4", 32'(count), 1);
        chk("sub_alu_a_hold", 32'(alu_a), 5);

        // 3: fill to 4, overflow, undo clears
        pulse_enter(16'd7); tick();
        pulse_enter(16'd8); tick();
        pulse_enter(16'd1); tick();
        chk("fill_count", 32'(count), 4);
        chk("fill_top", 32'(top), 1);
        pulse_enter(16'd9);
        chk("ovf_flag", 32'(err_overflow), 1);
        chk("ovf_busy", 32'(busy), 0);
        tick();
        chk("ovf_count", 32'(count), 4);
        chk("ovf_top", 32'(top), 1);
        pulse_undo();
        chk("undo_status", 32'(status), 2);
        chk("undo_clr_ovf", 32'(err_overflow), 0);
        tick();
        chk("undo_count", 32'(count), 3);
        chk("undo_top", 32'(top), 8);

        // 4: underflow on op and undo
        pulse_undo(); tick();
        pulse_undo(); tick();
        chk("down_count", 32'(count), 1);
        chk("down_top", 32'(top), 2);
        pulse_op(2'b00);
        chk("op_unf_flag", 32'(err_underflow), 1);
        chk("op_unf_busy", 32'(busy), 0);
        chk("op_unf_count", 32'(count), 1);
        pulse_undo();
        chk("undo_clr_unf", 32'(err_underflow), 0);
        tick();
        chk("empty_count", 32'(count), 0);
        chk("empty_top", 32'(top), 0);
        pulse_undo();
        chk("undo_unf_flag", 32'(err_underflow), 1);
        chk("undo_unf_count", 32'(count), 0);

        // 5: coincident pulses -> push only; op during FETCH ignored
        enter_pulse = 1'b1;
        op_pulse    = 1'b1;
        undo_pulse  = 1'b1;
        data_in     = 16'd6;
        opcode_in   = 2'b00;
        tick();
        enter_pulse = 1'b0;
        op_pulse    = 1'b0;
        undo_pulse  = 1'b0;
        chk("prio_status", 32'(status), 1);
        chk("prio_clr_unf", 32'(err_underflow), 0);
        tick();
        chk("prio_count", 32'(count), 1);
        chk("prio_top", 32'(top), 6);
        pulse_enter(16'd4); tick();
        pulse_op(2'b10);
        op_pulse  = 1'b1;
        opcode_in = 2'b11;
        tick();
        op_pulse  = 1'b0;
        chk("and_alu_op", 32'(alu_opcode), 2);
        tick();
        tick();
        chk("and_top", 32'(top), 4);
        chk("and_count", 32'(count), 1);
        tick();
        chk("and_idle_after", 32'(busy), 0);
        chk("and_count_after", 32'(count), 1);
        chk("and_no_unf", 32'(err_underflow), 0);

        // Truncation: 4-5 and 0xFFFF+10
        pulse_enter(16'd5); tick();
        pulse_op(2'b01); tick(); tick(); tick();
        chk("sub_wrap_top", 32'(top), 32'h0000_FFFF);
        pulse_enter(16'd10); tick();
        pulse_op(2'b00); tick(); tick(); tick();
        chk("add_wrap_top", 32'(top), 9);
        chk("add_wrap_count", 32'(count), 1);

        // 6: reset during EXEC discards the operation
        pulse_enter(16'd1); tick();
        pulse_op(2'b11);
        tick();
        chk("rst_exec_status", 32'(status), 4);
        reset = 1'b1;
        tick();
        chk("rst_exec_state", 32'(status), 0);
        chk("rst_exec_count", 32'(count), 0);
        chk("rst_exec_top", 32'(top), 0);
        chk("rst_exec_alu_a", 32'(alu_a), 0);
        reset = 1'b0;
        tick();
        tick();
        chk("rst_exec_no_wb", 32'(count), 0);
        chk("rst_exec_busy", 32'(busy), 0);
        chk("rst_exec_err", 32'({err_overflow, err_underflow}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
